ram_16x8_loader: RTL and testbench
==================================

// Module: ram_16x8_loader
// PURPOSE
//  16x8 program/data RAM for the 8-bit CPU; consumer end of the 4-bit address held by the MAR.
//  Run mode: addressed byte driven onto the 8-bit bus on ram_out; bus byte stored on ram_in.
//  Program mode: a loader FSM fills all 16 words sequentially from an external byte stream
//  (valid/ready handshake) before the CPU runs.
// PARAMETERS
//  AW     4    address width (matches MAR output)
//  DW     8    data / bus width
//  DEPTH  16   words; must equal 2**AW
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  ram_add_4    in   AW  address from MAR
//  ram_in       in   1   run mode: write ram_bus_8_i to mem[ram_add_4]
//  ram_out      in   1   run mode: drive mem[ram_add_4] onto bus
//  ram_bus_8_i  in   DW  byte from bus
//  ram_bus_8_o  out  DW  byte to bus
//  ram_bus_oe   out  1   bus drive enable
//  prog_mode    in   1   1 = loader owns RAM, 0 = CPU owns RAM
//  prog_valid   in   1   prog_data_8 valid
//  prog_data_8  in   DW  program byte
//  prog_ready   out  1   loader accepts byte this cycle
//  prog_addr    out  AW  address next byte is written to
//  prog_done    out  1   all DEPTH words loaded
// BEHAVIOUR
//  Reset: all mem words 8'h00, FSM=IDLE, prog_addr=0, prog_ready=0, prog_done=0,
//   ram_bus_oe=0, ram_bus_8_o=mem[ram_add_4] (=0).
//  FSM states IDLE / LOAD / DONE (registered):
//   IDLE: prog_mode=1 -> LOAD, prog_addr<=0. CPU access enabled only in IDLE.
//   LOAD: prog_ready=1 (combinational from state). Accept = prog_valid & prog_ready:
//    mem[prog_addr]<=prog_data_8, prog_addr<=prog_addr+1. Accept at prog_addr=DEPTH-1
//    -> DONE, prog_addr wraps to 0. prog_valid=0 -> hold, no write.
//   DONE: prog_done=1, prog_ready=0, incoming bytes ignored; prog_mode=0 -> IDLE.
//   prog_mode=0 during LOAD -> IDLE next edge, words already written kept, prog_addr<=0,
//    accept in that same cycle is still honoured (state is LOAD).
//  Run read: ram_bus_8_o = mem[ram_add_4] combinational, zero latency;
//   ram_bus_oe = ram_out & (state==IDLE) & ~prog_mode.
//  Run write: ram_in & (state==IDLE) & ~prog_mode at edge -> mem[ram_add_4]<=ram_bus_8_i.
//  ram_in & ram_out together: write at edge, bus shows old word until edge, new word after.
//  ram_in/ram_out in LOAD/DONE: ignored, oe=0, no write.
//  prog_mode rising same edge as ram_in in IDLE: write suppressed (~prog_mode gate).
//  Reset mid-LOAD: memory cleared, FSM IDLE; reload required.
// STRUCTURE
//  Shared package: AW/DW/DEPTH defaults, FSM state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
//  Sub-module: ram_loader_fsm (state, prog_addr, prog_ready/done, write strobe + addr mux);
//  top holds the register array and run-mode read/write muxing.
// TESTING
//  1 Reset: pulse rst_n low mid-cycle -> all 16 words read 8'h00, oe=0, prog_done=0.
//  2 Load: prog_mode=1, stream 8'h10..8'h1F back-to-back -> prog_done=1 after 16th accept,
//    run-mode reads addr 0..F return 8'h10..8'h1F.
//  3 Stall: gaps in prog_valid during load -> prog_addr holds, no write, final contents as test 2.
//  4 Abort: drop prog_mode after 5 bytes 8'hA0..8'hA4 -> IDLE, addr 0..4 = A0..A4, 5..F unchanged,
//    re-entry restarts at prog_addr=0.
//  5 Run R/W: addr 4'h7, bus 8'h5A, ram_in+ram_out -> bus shows old word then 8'h5A next cycle.
//  6 Lockout: ram_in/ram_out pulsed while in LOAD and DONE -> oe stays 0, no memory change.

Source files
------------

// File: rtl/ram_16x8_loader_pkg.sv
// rtl/ram_16x8_loader_pkg.sv - shared sizes and loader state encoding
// Purpose: geometry of the 16x8 program/data RAM and the loader FSM state type.
// Ports: none (package).
package ram_16x8_loader_pkg;

  localparam int AW    = 4;   // address width, matches the MAR
  localparam int DW    = 8;   // data / bus width
  localparam int DEPTH = 16;  // words, equals 2**AW

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ram_16x8_loader_if.sv
// rtl/ram_16x8_loader_if.sv - CPU bus and program-stream signals of the RAM
// Purpose: bundles the run-mode bus port and the loader byte stream.
// Ports (all members):
//   ram_add_4, ram_in, ram_out, ram_bus_8_i        CPU side -> RAM
//   ram_bus_8_o, ram_bus_oe                         RAM -> CPU bus
//   prog_mode, prog_valid, prog_data_8              loader source -> RAM
//   prog_ready, prog_addr, prog_done                RAM -> loader source
// Modports: master = CPU/loader side, slave = RAM.
interface ram_16x8_loader_if;
  import ram_16x8_loader_pkg::*;

  logic [AW-1:0] ram_add_4;
  logic          ram_in;
  logic          ram_out;
  logic [DW-1:0] ram_bus_8_i;
  logic [DW-1:0] ram_bus_8_o;
  logic          ram_bus_oe;
  logic          prog_mode;
  logic          prog_valid;
  logic [DW-1:0] prog_data_8;
  logic          prog_ready;
  logic [AW-1:0] prog_addr;
  logic          prog_done;

  modport master (
    output ram_add_4, ram_in, ram_out, ram_bus_8_i,
    output prog_mode, prog_valid, prog_data_8,
    input  ram_bus_8_o, ram_bus_oe, prog_ready, prog_addr, prog_done
  );

  modport slave (
    input  ram_add_4, ram_in, ram_out, ram_bus_8_i,
    input  prog_mode, prog_valid, prog_data_8,
    output ram_bus_8_o, ram_bus_oe, prog_ready, prog_addr, prog_done
  );

endinterface

// File: rtl/ram_16x8_loader_fsm.sv
// rtl/ram_16x8_loader_fsm.sv - loader FSM and RAM write-port arbitration
// Purpose: sequences IDLE/LOAD/DONE, tracks the load address and decides who
//   writes the RAM (loader stream or CPU bus) each cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   prog_mode, prog_valid loader mode request and byte valid
//   ram_in, ram_add_4     CPU write request and address
//   prog_ready, prog_done handshake ready, load complete
//   prog_addr             address the next loader byte goes to
//   cpu_en                CPU owns the RAM this cycle
//   mem_we, mem_waddr     RAM write strobe and address
//   mem_wsel_load         1 = write data comes from the loader stream
module ram_loader_fsm
  import ram_16x8_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_mode,
  input  logic          prog_valid,
  input  logic          ram_in,
  input  logic [AW-1:0] ram_add_4,
  output logic          prog_ready,
  output logic          prog_done,
  output logic [AW-1:0] prog_addr,
  output logic          cpu_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wsel_load
);

  ld_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          accept;

  assign accept = (state_q == ST_LOAD) & prog_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (prog_mode) begin
          state_d = ST_LOAD;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        // Natural AW-bit wrap takes the address back to 0 after the last word.
        if (accept) addr_d = addr_q + 1'b1;
        // Dropping prog_mode aborts; a byte accepted in this cycle is still written.
        if (!prog_mode) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end else if (accept && addr_q == AW'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!prog_mode) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign prog_ready = (state_q == ST_LOAD);
  assign prog_done  = (state_q == ST_DONE);
  assign prog_addr  = addr_q;

  // prog_mode gates the CPU so a mode request on the same edge as ram_in wins.
  assign cpu_en        = (state_q == ST_IDLE) & ~prog_mode;
  assign mem_wsel_load = accept;
  assign mem_we        = accept | (cpu_en & ram_in);
  assign mem_waddr     = accept ? addr_q : ram_add_4;

endmodule

// File: rtl/ram_16x8_loader.sv
// rtl/ram_16x8_loader.sv - 16x8 program/data RAM with sequential stream loader
// Purpose: register array read/written by the CPU bus in run mode, filled by
//   ram_loader_fsm from a valid/ready byte stream in program mode.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears all words)
//   bus          ram_16x8_loader_if.slave: CPU bus and loader stream
module ram_16x8_loader
  import ram_16x8_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ram_16x8_loader_if.slave   bus
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] wdata_d;
  logic          cpu_en;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_wsel_load;

  ram_loader_fsm u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .prog_mode     (bus.prog_mode),
    .prog_valid    (bus.prog_valid),
    .ram_in        (bus.ram_in),
    .ram_add_4     (bus.ram_add_4),
    .prog_ready    (bus.prog_ready),
    .prog_done     (bus.prog_done),
    .prog_addr     (bus.prog_addr),
    .cpu_en        (cpu_en),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wsel_load (mem_wsel_load)
  );

  always_comb begin
    wdata_d = bus.ram_bus_8_i;
    if (mem_wsel_load) wdata_d = bus.prog_data_8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= wdata_d;
    end
  end

  // Zero-latency read: a simultaneous write shows up only after the edge.
  assign bus.ram_bus_8_o = mem_q[bus.ram_add_4];
  assign bus.ram_bus_oe  = bus.ram_out & cpu_en;

endmodule

// File: tb/tb_ram_16x8_loader.sv
// tb/tb_ram_16x8_loader.sv - self-checking bench for ram_16x8_loader
module tb_ram_16x8_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_16x8_loader_if bus ();

  ram_16x8_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM contents plus "loading" / "loaded" flags and a fill pointer.
  logic [7:0] m_mem [16];
  bit         m_loading, m_loaded;
  int         m_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_loading = 0; m_loaded = 0; m_ptr = 0;
    end else if (m_loading) begin
      if (bus.prog_valid) begin
        m_mem[m_ptr] = bus.prog_data_8;
        m_ptr = m_ptr + 1;
      end
      if (!bus.prog_mode) begin
        m_loading = 0; m_ptr = 0;
      end else if (m_ptr == 16) begin
        m_loading = 0; m_loaded = 1; m_ptr = 0;
      end
    end else if (m_loaded) begin
      if (!bus.prog_mode) m_loaded = 0;
    end else begin
      if (bus.prog_mode) begin
        m_loading = 1; m_ptr = 0;
      end else if (bus.ram_in) begin
        m_mem[bus.ram_add_4] = bus.ram_bus_8_i;
      end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_o", bus.ram_bus_8_o, m_mem[bus.ram_add_4]);
      chk("oe", bus.ram_bus_oe,
          bus.ram_out & ~m_loading & ~m_loaded & ~bus.prog_mode);
      chk("ready", bus.prog_ready, m_loading);
      chk("done", bus.prog_done, m_loaded);
      chk("paddr", bus.prog_addr, m_ptr[3:0]);
    end
  end

  task automatic idle_inputs();
    bus.ram_add_4 = '0; bus.ram_in = 0; bus.ram_out = 0; bus.ram_bus_8_i = '0;
    bus.prog_mode = 0; bus.prog_valid = 0; bus.prog_data_8 = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(posedge clk); #1;
    bus.ram_add_4 = a; bus.ram_out = 1; bus.ram_in = 0;
    #1;
    chk(name, bus.ram_bus_8_o, exp);
    chk({name, "_oe"}, bus.ram_bus_oe, 1);
    bus.ram_out = 0;
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  // Stream n bytes base, base+1, ... with gap_pct% idle cycles; noisy pulses CPU
  // controls throughout. Leaves prog_mode high (caller decides abort or finish).
  task automatic load(input logic [7:0] base, input int n, input int gap_pct, input bit noisy);
    int idx = 0;
    int cyc = 0;
    @(posedge clk); #1;
    bus.prog_mode = 1;
    if (noisy) begin
      bus.ram_in = 1; bus.ram_add_4 = 4'h3; bus.ram_bus_8_i = 8'hEE;
    end
    @(posedge clk); #1;
    chk("enter_paddr", bus.prog_addr, 0);
    while (idx < n && cyc < 400) begin
      bus.prog_valid  = ($urandom_range(99) >= gap_pct);
      bus.prog_data_8 = base + 8'(idx);
      if (noisy) begin
        bus.ram_in = 1'($urandom); bus.ram_out = 1'($urandom);
        bus.ram_add_4 = 4'($urandom); bus.ram_bus_8_i = 8'($urandom);
      end
      @(posedge clk); #1;
      if (bus.prog_valid) idx++;
      cyc++;
    end
    chk("load_progress", idx, n);
    bus.prog_valid = 0; bus.ram_in = 0; bus.ram_out = 0;
  endtask

  task automatic leave_prog();
    bus.prog_mode = 0; bus.prog_valid = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    // 1: mid-cycle reset clears everything
    mid_reset();
    chk_en = 1;
    #1;
    chk("rst_oe", bus.ram_bus_oe, 0);
    chk("rst_done", bus.prog_done, 0);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "rst_word");

    // 2: back-to-back load
    load(8'h10, 16, 0, 0);
    chk("load_done", bus.prog_done, 1);
    chk("load_ready", bus.prog_ready, 0);
    leave_prog();
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h10 + 8'(i), "load_word");

    // 3: stalled load gives the same image
    load(8'h10, 16, 40, 0);
    chk("stall_done", bus.prog_done, 1);
    leave_prog();
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h10 + 8'(i), "stall_word");

    // 4: abort after 5 bytes, then re-entry restarts at 0
    load(8'hA0, 5, 20, 0);
    chk("abort_paddr", bus.prog_addr, 5);
    leave_prog();
    chk("abort_done", bus.prog_done, 0);
    chk("abort_paddr_idle", bus.prog_addr, 0);
    for (int i = 0; i < 16; i++)
      rd(4'(i), (i < 5) ? 8'hA0 + 8'(i) : 8'h10 + 8'(i), "abort_word");
    bus.prog_mode = 1;
    @(posedge clk); #1;
    chk("reentry_paddr", bus.prog_addr, 0);
    leave_prog();

    // 5: simultaneous read/write shows old word, then new word
    @(posedge clk); #1;
    bus.ram_add_4 = 4'h7; bus.ram_bus_8_i = 8'h5A; bus.ram_in = 1; bus.ram_out = 1;
    #1;
    chk("rw_old", bus.ram_bus_8_o, 8'h17);
    @(posedge clk); #1;
    bus.ram_in = 0;
    chk("rw_new", bus.ram_bus_8_o, 8'h5A);
    bus.ram_out = 0;

    // 6: CPU lockout during LOAD and DONE (and mode rising with ram_in)
    load(8'h40, 16, 30, 1);
    for (int k = 0; k < 6; k++) begin
      bus.ram_in = 1'($urandom); bus.ram_out = 1;
      bus.ram_add_4 = 4'($urandom); bus.ram_bus_8_i = 8'($urandom);
      bus.prog_valid = 1; bus.prog_data_8 = 8'hFF;
      #1;
      chk("lock_oe", bus.ram_bus_oe, 0);
      @(posedge clk); #1;
    end
    bus.ram_in = 0; bus.ram_out = 0;
    leave_prog();
    rd(4'h3, 8'h43, "lock_word3");
    rd(4'hF, 8'h4F, "lock_wordF");

    // Random run-mode traffic
    for (int k = 0; k < 300; k++) begin
      bus.ram_add_4 = 4'($urandom); bus.ram_bus_8_i = 8'($urandom);
      bus.ram_in = 1'($urandom); bus.ram_out = 1'($urandom);
      @(posedge clk); #1;
    end

    // Random everything, including aborts coinciding with accepts
    for (int k = 0; k < 600; k++) begin
      bus.ram_add_4 = 4'($urandom); bus.ram_bus_8_i = 8'($urandom);
      bus.ram_in = 1'($urandom); bus.ram_out = 1'($urandom);
      if ($urandom_range(19) == 0) bus.prog_mode = ~bus.prog_mode;
      bus.prog_valid = ($urandom_range(3) != 0);
      bus.prog_data_8 = 8'($urandom);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;

    // Reset mid-LOAD clears memory and returns to IDLE
    load(8'hC0, 6, 0, 0);
    bus.prog_mode = 0;
    mid_reset();
    #1;
    chk("rst_load_ready", bus.prog_ready, 0);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "rst_load_word");

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
